// File: rtl/mt_pkg.sv
// Constants shared by the multithreaded register file and the barrel-thread scheduler.
package mt_pkg;

  localparam int MT_NUM_THREADS = 8;
  localparam int MT_PIPE_DEPTH  = 4;

  typedef enum logic [1:0] {
    ST_RUN    = 2'd0,
    ST_DRAIN  = 2'd1,
    ST_SWITCH = 2'd2
  } sched_state_t;

endpackage

// File: rtl/mt_wb_delay.sv
// Valid+ID shift register from issue to writeback. The valid flag is the MSB of each entry.
module mt_wb_delay #(
  parameter int DEPTH = 4,
  parameter int WIDTH = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [WIDTH-1:0] in_data,
  output logic [WIDTH-1:0] out_data,
  output logic             any_valid
);

  logic [WIDTH-1:0] stages [DEPTH];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < DEPTH; i++) stages[i] <= '0;
    end else begin
      stages[0] <= in_data;
      for (int i = 1; i < DEPTH; i++) stages[i] <= stages[i-1];
    end
  end

  always_comb begin
    any_valid = 1'b0;
    for (int i = 0; i < DEPTH; i++) any_valid = any_valid | stages[i][WIDTH-1];
  end

  assign out_data = stages[DEPTH-1];

endmodule

// File: rtl/mt_thread_sched.sv
// Barrel-thread scheduler: round-robin issue of eligible threads, delayed writeback IDs,
// and a drain-then-switch sequence for the thread-group (register bank) select.
module mt_thread_sched
  import mt_pkg::*;
#(
  parameter int NUM_THREADS  = MT_NUM_THREADS,
  parameter int BITS_THREADS = $clog2(NUM_THREADS),
  parameter int PIPE_DEPTH   = MT_PIPE_DEPTH
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic [NUM_THREADS-1:0]  thread_en,
  input  logic                    stall_set,
  input  logic                    stall_clr,
  input  logic [BITS_THREADS-1:0] stall_tid,
  input  logic [BITS_THREADS-1:0] clr_tid,
  input  logic                    grp_switch_req,
  output logic                    grp_switch_ack,
  output logic                    issue_valid,
  output logic [BITS_THREADS-1:0] tid_read,
  output logic                    wb_valid,
  output logic [BITS_THREADS-1:0] tid_write,
  output logic                    tgrp,
  output logic [1:0]              fsm_state
);

  // Group switch handshake: grp_switch_req is a level; the switch completes with a
  // single-cycle grp_switch_ack coincident with the new tgrp. Holding req past the
  // ack cycle requests another toggle.

  sched_state_t state_q, state_d;

  logic [NUM_THREADS-1:0]  stalled_q [2];
  logic [NUM_THREADS-1:0]  stall_next;
  logic [NUM_THREADS-1:0]  eligible;
  logic                    stall_bank;
  logic [BITS_THREADS-1:0] last_tid_q;
  logic [BITS_THREADS-1:0] pick_tid;
  logic [BITS_THREADS-1:0] cand;
  logic                    pick_found;
  logic                    issue_d;
  logic                    line_busy;

  assign fsm_state = state_q;

  // In the SWITCH cycle the bank flips at this same edge, so stall updates target the new group.
  assign stall_bank = (state_q == ST_SWITCH) ? ~tgrp : tgrp;

  always_comb begin
    stall_next = stalled_q[stall_bank];
    if (stall_clr) stall_next[clr_tid]   = 1'b0;
    if (stall_set) stall_next[stall_tid] = 1'b1;
  end

  assign eligible = thread_en & ~stalled_q[tgrp];

  // Search starts just after last_tid; i == NUM_THREADS wraps back onto last_tid itself.
  always_comb begin
    pick_found = 1'b0;
    pick_tid   = last_tid_q;
    cand       = last_tid_q;
    for (int i = 1; i <= NUM_THREADS; i++) begin
      cand = last_tid_q + BITS_THREADS'(i);
      if (!pick_found && eligible[cand]) begin
        pick_found = 1'b1;
        pick_tid   = cand;
      end
    end
  end

  assign issue_d = (state_q == ST_RUN) && !grp_switch_req && pick_found;

  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_RUN:    if (grp_switch_req) state_d = ST_DRAIN;
      ST_DRAIN:  if (!line_busy && !wb_valid) state_d = ST_SWITCH;
      ST_SWITCH: state_d = ST_RUN;
      default:   state_d = ST_RUN;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q        <= ST_RUN;
      stalled_q[0]   <= '0;
      stalled_q[1]   <= '0;
      last_tid_q     <= '1;
      issue_valid    <= 1'b0;
      tid_read       <= '0;
      tgrp           <= 1'b0;
      grp_switch_ack <= 1'b0;
    end else begin
      state_q               <= state_d;
      stalled_q[stall_bank] <= stall_next;
      issue_valid           <= issue_d;
      grp_switch_ack        <= (state_q == ST_SWITCH);
      if (issue_d) begin
        tid_read   <= pick_tid;
        last_tid_q <= pick_tid;
      end else if (state_q == ST_SWITCH) begin
        last_tid_q <= '1;
      end
      if (state_q == ST_SWITCH) tgrp <= ~tgrp;
    end
  end

  mt_wb_delay #(
    .DEPTH (PIPE_DEPTH),
    .WIDTH (BITS_THREADS + 1)
  ) u_wb_delay (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_data   ({issue_valid, tid_read}),
    .out_data  ({wb_valid, tid_write}),
    .any_valid (line_busy)
  );

endmodule
